// File: rtl/dff_bist_pkg.sv
// Shared definitions for the flip-flop BIST driver/checker.
// Latency: n/a (types only).
// Backpressure: n/a.
package dff_bist_pkg;

    // Run sequencing states of the tester FSM
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DRIVE = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/bist_cmp_pipe.sv
// Two-stage expected-bit/index/valid delay line with mismatch detect against q_in.
// Latency: a pushed bit is compared two edges after it is pushed.
// Backpressure: none; one push per cycle, compare result is combinational.
module bist_cmp_pipe #(
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_vld,
    input  logic             push_bit,
    input  logic [IDX_W-1:0] push_idx,
    input  logic             q_in,
    output logic             mismatch,
    output logic [IDX_W-1:0] mis_idx
);

    logic             s1_vld;
    logic             s1_bit;
    logic [IDX_W-1:0] s1_idx;
    logic             s2_vld;
    logic             s2_bit;
    logic [IDX_W-1:0] s2_idx;

    // Stage 1 tracks the bit the FSM is driving now; stage 2 lines up with
    // the value the flop under test presents on q_in one edge later.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld <= 1'b0;
            s1_bit <= 1'b0;
            s1_idx <= '0;
            s2_vld <= 1'b0;
            s2_bit <= 1'b0;
            s2_idx <= '0;
        end else begin
            s1_vld <= push_vld;
            s1_bit <= push_bit;
            s1_idx <= push_idx;
            s2_vld <= s1_vld;
            s2_bit <= s1_bit;
            s2_idx <= s1_idx;
        end
    end

    // Flag a wrong Q only for bits that were really driven in this run
    always_comb begin
        mismatch = s2_vld && (q_in != s2_bit);
        mis_idx  = s2_idx;
    end

endmodule

// File: rtl/dff_bist.sv
// Drives a fixed pattern into a D flip-flop and checks Q bit by bit.
// Latency: done rises PATTERN_LEN+1 cycles after the accepted start edge.
// Backpressure: none; start is ignored while a run is busy.
module dff_bist
    import dff_bist_pkg::*;
#(
    parameter int                     PATTERN_LEN = 16,
    parameter logic [PATTERN_LEN-1:0] PATTERN     = 16'hB2D4,
    parameter int                     ERR_W       = 8,
    localparam int                    IDX_W       = $clog2(PATTERN_LEN)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             d_out,
    input  logic             q_in,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [IDX_W-1:0] first_fail
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(PATTERN_LEN - 1);

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic             flush_last;
    logic             accept;
    logic             push_vld;
    logic [IDX_W-1:0] push_idx;
    logic             push_bit;
    logic             mismatch;
    logic [IDX_W-1:0] mis_idx;

    // Select the bit driven at this edge; it also enters the compare pipe
    always_comb begin
        accept   = start && ((state == ST_IDLE) || (state == ST_DONE));
        push_vld = accept || (state == ST_DRIVE);
        push_idx = accept ? '0 : idx;
        push_bit = PATTERN[push_idx];
    end

    bist_cmp_pipe #(
        .IDX_W (IDX_W)
    ) u_cmp_pipe (
        .clk      (clk),
        .rst      (rst),
        .push_vld (push_vld),
        .push_bit (push_bit),
        .push_idx (push_idx),
        .q_in     (q_in),
        .mismatch (mismatch),
        .mis_idx  (mis_idx)
    );

    // Run FSM with registered outputs and the saturating error tally
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            idx        <= '0;
            flush_last <= 1'b0;
            d_out      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= '0;
            first_fail <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start) begin
                        state      <= ST_DRIVE;
                        d_out      <= push_bit;
                        idx        <= IDX_W'(1);
                        flush_last <= 1'b0;
                        busy       <= 1'b1;
                        done       <= 1'b0;
                        pass       <= 1'b0;
                        err_count  <= '0;
                        first_fail <= '0;
                    end
                end
                ST_DRIVE: begin
                    d_out <= push_bit;
                    if (idx == LAST_IDX) begin
                        state <= ST_FLUSH;
                    end else begin
                        idx <= idx + IDX_W'(1);
                    end
                end
                ST_FLUSH: begin
                    d_out <= 1'b0;
                    if (flush_last) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        // The last compare lands on this same edge
                        pass  <= (err_count == '0) && !mismatch;
                    end else begin
                        flush_last <= 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            // Compares only happen while the pipe holds bits of this run
            if (((state == ST_DRIVE) || (state == ST_FLUSH)) && mismatch) begin
                if (err_count != {ERR_W{1'b1}}) begin
                    err_count <= err_count + ERR_W'(1);
                end
                if (err_count == '0) begin
                    first_fail <= mis_idx;
                end
            end
        end
    end

endmodule
